// File: rtl/conv2d_window_gen.sv
// Sliding-window generator for 2-D convolution over a raster stream.
// Keeps a K-row ring of input pixels and emits one zero-padded KxK window per
// (oy, ox, channel) position; the input side stalls while a row of windows drains.
module conv2d_window_gen #(
  parameter int IN_HEIGHT   = 5,
  parameter int IN_WIDTH    = 4,
  parameter int IN_CHANNEL  = 4,
  parameter int WORD_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PADDING     = 1
) (
  input  logic                                          i_aclk,
  input  logic                                          i_areset,
  input  logic                                          i_tvalid,
  output logic                                          o_tready,
  input  logic [WORD_WIDTH-1:0]                         i_tdata,
  output logic                                          o_tvalid,
  input  logic                                          i_tready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*WORD_WIDTH-1:0] o_tdata,
  output logic                                          o_tlast
);

  localparam int OUT_H = (IN_HEIGHT + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int OUT_W = (IN_WIDTH + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
  localparam int DEPTH = KERNEL_SIZE * IN_WIDTH * IN_CHANNEL;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = 16;

  localparam logic [CW-1:0] C_LAST    = CW'(IN_CHANNEL - 1);
  localparam logic [CW-1:0] X_LAST    = CW'(IN_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(IN_HEIGHT - 1);
  localparam logic [CW-1:0] Y_DONE    = CW'(IN_HEIGHT);
  localparam logic [CW-1:0] OX_LAST   = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OY_LAST   = CW'(OUT_H - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] KSZ       = CW'(KERNEL_SIZE);
  localparam logic [CW-1:0] STEP      = CW'(STRIDE);
  // Ring slot holding the top window row of oy=0 (row -P maps to slot K-P).
  localparam logic [CW-1:0] TOP_INIT  = CW'((KERNEL_SIZE - PADDING) % KERNEL_SIZE);

  typedef enum logic [1:0] {StFill, StEmit, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   in_c_q, in_c_d, in_x_q, in_x_d, in_y_q, in_y_d;
  logic [CW-1:0]   wr_slot_q, wr_slot_d, top_slot_q, top_slot_d;
  logic [CW-1:0]   oc_q, oc_d, ox_q, ox_d, oy_q, oy_d;
  logic [CW-1:0]   slot_sum;
  logic            in_hs, out_hs, row_end;
  logic [AW-1:0]   wr_addr;
  logic [WORD_WIDTH-1:0] ring_q [DEPTH];
  logic [KERNEL_SIZE*KERNEL_SIZE*WORD_WIDTH-1:0] window;

  // Last input row needed (clipped to the image) before output row oy can be emitted.
  function automatic int need_row(input int oy);
    int r;
    r = oy * STRIDE - PADDING + KERNEL_SIZE - 1;
    return (r < IN_HEIGHT - 1) ? r : IN_HEIGHT - 1;
  endfunction

  assign o_tready = (state_q != StEmit);
  assign o_tvalid = (state_q == StEmit);
  assign o_tlast  = o_tvalid && (oy_q == OY_LAST) && (ox_q == OX_LAST) && (oc_q == C_LAST);
  assign o_tdata  = o_tvalid ? window : '0;
  assign wr_addr  = AW'(int'(wr_slot_q) * IN_WIDTH * IN_CHANNEL + int'(in_x_q) * IN_CHANNEL
                        + int'(in_c_q));

  // State and counter registers with synchronous reset.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state_q    <= StFill;
      in_c_q     <= '0;
      in_x_q     <= '0;
      in_y_q     <= '0;
      wr_slot_q  <= '0;
      top_slot_q <= TOP_INIT;
      oc_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_c_q     <= in_c_d;
      in_x_q     <= in_x_d;
      in_y_q     <= in_y_d;
      wr_slot_q  <= wr_slot_d;
      top_slot_q <= top_slot_d;
      oc_q       <= oc_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
    end
  end

  // Ring write in FILL only; words accepted in DRAIN are dropped.
  always_ff @(posedge i_aclk) begin
    if (state_q == StFill && i_tvalid) ring_q[wr_addr] <= i_tdata;
  end

  // Next-state: input position tracking, output position stepping and FSM.
  always_comb begin
    state_d    = state_q;
    in_c_d     = in_c_q;
    in_x_d     = in_x_q;
    in_y_d     = in_y_q;
    wr_slot_d  = wr_slot_q;
    top_slot_d = top_slot_q;
    oc_d       = oc_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    in_hs      = i_tvalid && o_tready;
    out_hs     = o_tvalid && i_tready;
    row_end    = (in_x_q == X_LAST) && (in_c_q == C_LAST);
    slot_sum   = top_slot_q + STEP;
    if (slot_sum >= KSZ) slot_sum = slot_sum - KSZ;

    if (in_hs) begin
      if (in_c_q != C_LAST) begin
        in_c_d = in_c_q + 1'b1;
      end else begin
        in_c_d = '0;
        if (in_x_q != X_LAST) begin
          in_x_d = in_x_q + 1'b1;
        end else begin
          in_x_d = '0;
          in_y_d = in_y_q + 1'b1;
        end
      end
    end

    unique case (state_q)
      StFill: begin
        if (in_hs && row_end) begin
          wr_slot_d = (wr_slot_q == SLOT_LAST) ? '0 : wr_slot_q + 1'b1;
          if (int'(in_y_q) == need_row(int'(oy_q))) state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_hs) begin
          if (oc_q != C_LAST) begin
            oc_d = oc_q + 1'b1;
          end else begin
            oc_d = '0;
            if (ox_q != OX_LAST) begin
              ox_d = ox_q + 1'b1;
            end else begin
              ox_d = '0;
              if (oy_q != OY_LAST) begin
                oy_d       = oy_q + 1'b1;
                top_slot_d = slot_sum;
                // Bottom-padding rows need no new input: stay in EMIT.
                state_d    = (int'(in_y_q) > need_row(int'(oy_q) + 1)) ? StEmit : StFill;
              end else begin
                oy_d       = '0;
                top_slot_d = TOP_INIT;
                if (in_y_q == Y_DONE) begin
                  state_d   = StFill;
                  in_y_d    = '0;
                  wr_slot_d = '0;
                end else begin
                  state_d = StDrain;
                end
              end
            end
          end
        end
      end
      StDrain: begin
        if (in_hs && row_end && in_y_q == Y_LAST) begin
          state_d   = StFill;
          in_y_d    = '0;
          wr_slot_d = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Window assembly from the ring with zero fill outside the image.
  always_comb begin
    int iy, ix, slot;
    window = '0;
    iy     = 0;
    ix     = 0;
    slot   = 0;
    for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
      iy   = int'(oy_q) * STRIDE - PADDING + ky;
      slot = int'(top_slot_q) + ky;
      if (slot >= KERNEL_SIZE) slot = slot - KERNEL_SIZE;
      for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
        ix = int'(ox_q) * STRIDE - PADDING + kx;
        if (iy >= 0 && iy < IN_HEIGHT && ix >= 0 && ix < IN_WIDTH) begin
          window[(ky*KERNEL_SIZE+kx)*WORD_WIDTH +: WORD_WIDTH] =
              ring_q[AW'((slot * IN_WIDTH + ix) * IN_CHANNEL + int'(oc_q))];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2d_window_gen.sv
// Directed bench for conv2d_window_gen: four configurations, windows checked
// against a direct formula model plus hand-computed constants.
module tb_conv2d_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance configuration: 0 = 4x4 S1 P1, 1 = 5x5 S2 P0, 2 = 6x6 S2 P0, 3 = 4x4 C2 S1 P1.
  int ph [4] = '{4, 5, 6, 4};
  int pw [4] = '{4, 5, 6, 4};
  int pc [4] = '{1, 1, 1, 2};
  int ps [4] = '{1, 2, 2, 1};
  int pp [4] = '{1, 0, 0, 1};

  logic        rst  [4];
  logic        tv_i [4];
  logic        tr_o [4];
  logic [7:0]  td_i [4];
  logic        tv_o [4];
  logic        tr_i [4];
  logic [71:0] td_o [4];
  logic        tl_o [4];

  int          in_idx   [4];
  int          frame_no [4];
  logic [71:0] cap [64];
  int          checks = 0;
  int          errors = 0;

  conv2d_window_gen #(.IN_HEIGHT(4), .IN_WIDTH(4), .IN_CHANNEL(1), .WORD_WIDTH(8),
    .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)) u_dut0 (
    .i_aclk(clk), .i_areset(rst[0]), .i_tvalid(tv_i[0]), .o_tready(tr_o[0]), .i_tdata(td_i[0]),
    .o_tvalid(tv_o[0]), .i_tready(tr_i[0]), .o_tdata(td_o[0]), .o_tlast(tl_o[0]));
  conv2d_window_gen #(.IN_HEIGHT(5), .IN_WIDTH(5), .IN_CHANNEL(1), .WORD_WIDTH(8),
    .KERNEL_SIZE(3), .STRIDE(2), .PADDING(0)) u_dut1 (
    .i_aclk(clk), .i_areset(rst[1]), .i_tvalid(tv_i[1]), .o_tready(tr_o[1]), .i_tdata(td_i[1]),
    .o_tvalid(tv_o[1]), .i_tready(tr_i[1]), .o_tdata(td_o[1]), .o_tlast(tl_o[1]));
  conv2d_window_gen #(.IN_HEIGHT(6), .IN_WIDTH(6), .IN_CHANNEL(1), .WORD_WIDTH(8),
    .KERNEL_SIZE(3), .STRIDE(2), .PADDING(0)) u_dut2 (
    .i_aclk(clk), .i_areset(rst[2]), .i_tvalid(tv_i[2]), .o_tready(tr_o[2]), .i_tdata(td_i[2]),
    .o_tvalid(tv_o[2]), .i_tready(tr_i[2]), .o_tdata(td_o[2]), .o_tlast(tl_o[2]));
  conv2d_window_gen #(.IN_HEIGHT(4), .IN_WIDTH(4), .IN_CHANNEL(2), .WORD_WIDTH(8),
    .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)) u_dut3 (
    .i_aclk(clk), .i_areset(rst[3]), .i_tvalid(tv_i[3]), .o_tready(tr_o[3]), .i_tdata(td_i[3]),
    .o_tvalid(tv_o[3]), .i_tready(tr_i[3]), .o_tdata(td_o[3]), .o_tlast(tl_o[3]));

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int out_w(input int n);
    return (pw[n] + 2 * pp[n] - 3) / ps[n] + 1;
  endfunction

  function automatic int out_h(input int n);
    return (ph[n] + 2 * pp[n] - 3) / ps[n] + 1;
  endfunction

  function automatic int frame_sz(input int n);
    return ph[n] * pw[n] * pc[n];
  endfunction

  // Words that must arrive before the first window of a frame.
  function automatic int fill0(input int n);
    int r;
    r = 2 - pp[n];
    if (r > ph[n] - 1) r = ph[n] - 1;
    return (r + 1) * pw[n] * pc[n];
  endfunction

  // Expected window w of a frame, data word = ((y*W+x)*C+c).
  function automatic logic [71:0] exp_win(input int n, input int w);
    logic [71:0] r;
    int c, p, ox, oy, y, x;
    r  = '0;
    c  = w % pc[n];
    p  = w / pc[n];
    ox = p % out_w(n);
    oy = p / out_w(n);
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        y = oy * ps[n] - pp[n] + ky;
        x = ox * ps[n] - pp[n] + kx;
        if (y >= 0 && y < ph[n] && x >= 0 && x < pw[n]) r[(ky*3+kx)*8 +: 8] = 8'((y * pw[n] + x) * pc[n] + c);
      end
    end
    return r;
  endfunction

  // Streams words continuously and consumes windows until the frame ends (or abort_at windows).
  task automatic run_frame(input int n, input int stall_at, input int abort_at);
    int nwin, cyc, stalls, tot;
    bit seen;
    tot = out_h(n) * out_w(n) * pc[n];
    nwin = 0; cyc = 0; stalls = 0; seen = 1'b0;
    while (nwin < tot && nwin != abort_at && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      tv_i[n] = 1'b1;
      td_i[n] = 8'(in_idx[n] % frame_sz(n));
      tr_i[n] = !(nwin == stall_at && stalls < 3);
      chk("tready_is_not_tvalid", 72'(tr_o[n]), 72'(!tv_o[n]));
      if (!tr_i[n]) begin
        chk("valid_held_in_stall", 72'(tv_o[n]), 72'(1'b1));
        stalls++;
      end
      if (tv_o[n] === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          chk("words_before_first_window", 72'(in_idx[n]),
              72'(frame_no[n] * frame_sz(n) + fill0(n)));
        end
        chk("window", td_o[n], exp_win(n, nwin));
        if (tr_i[n]) begin
          chk("tlast", 72'(tl_o[n]), 72'(nwin == tot - 1));
          cap[nwin] = td_o[n];
          nwin++;
        end
      end
      if (tr_o[n] === 1'b1) in_idx[n]++;
    end
    chk("window_count", 72'(nwin), 72'((abort_at < 0) ? tot : abort_at));
    if (nwin == tot) frame_no[n]++;
    @(negedge clk);
    tv_i[n] = 1'b0;
    tr_i[n] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; tv_i[i] = 1'b0; tr_i[i] = 1'b0; td_i[i] = '0;
      in_idx[i] = 0; frame_no[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // Reset state.
    for (int i = 0; i < 4; i++) begin
      chk("reset_tready", 72'(tr_o[i]), 72'(1'b1));
      chk("reset_tvalid", 72'(tv_o[i]), 72'(1'b0));
    end
    chk("reset_tlast", 72'(tl_o[0]), 72'(1'b0));
    chk("reset_tdata", td_o[0], 72'h0);

    // 4x4, K3 S1 P1: 16 windows, tready drops after word 7.
    run_frame(0, -1, -1);
    chk("w0_first_window", cap[0], 72'h05_04_00_01_00_00_00_00_00);
    chk("w0_last_window", cap[15], 72'h00_00_00_00_0f_0e_00_0b_0a);

    // Downstream stall for 3 cycles mid-row.
    run_frame(0, 5, -1);

    // Reset pulse in the middle of EMIT, then a clean frame.
    run_frame(0, -1, 6);
    chk("pre_reset_in_emit", 72'(tv_o[0]), 72'(1'b1));
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("post_reset_tvalid", 72'(tv_o[0]), 72'(1'b0));
    chk("post_reset_tready", 72'(tr_o[0]), 72'(1'b1));
    chk("post_reset_tdata", td_o[0], 72'h0);
    in_idx[0] = 0;
    frame_no[0] = 0;
    run_frame(0, -1, -1);
    chk("w0_first_after_reset", cap[0], 72'h05_04_00_01_00_00_00_00_00);

    // 5x5, S2 P0: window(1,1).
    run_frame(1, -1, -1);
    chk("w1_window_1_1", cap[3], 72'h18_17_16_13_12_11_0e_0d_0c);

    // 6x6, S2 P0: row 5 drained, next frame starts clean.
    run_frame(2, -1, -1);
    chk("w2_frame1_first", cap[0], 72'h0e_0d_0c_08_07_06_02_01_00);
    run_frame(2, -1, -1);
    chk("w2_frame2_first", cap[0], 72'h0e_0d_0c_08_07_06_02_01_00);
    chk("w2_words_two_frames", 72'(in_idx[2]), 72'(66));

    // Two channels: windows alternate c=0/c=1.
    run_frame(3, -1, -1);
    chk("w3_c0_centre", 72'(cap[0][39:32]), 72'(8'd0));
    chk("w3_c1_centre", 72'(cap[1][39:32]), 72'(8'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
